slice_ctrl: RTL and testbench
=============================

// Module: slice_ctrl
// PURPOSE
// Sequencer for the slice_mem accumulator chain in the slicevm pipeline.
// Clears the accumulator FIFOs via download, then tracks pixel/block/window position per frame.
// Emits the aligned dvi/newblock/coefficient-address stream to the slice_mem bank.
// Flags when a detection window result is valid at the slice_mem outputs.
// PARAMETERS
// BLOCKSIZE  32   pixels per block edge (power of 2)
// WINCOLS    8    blocks per window row (power of 2)
// WINROWS    16   blocks per window column
// IMG_WIDTH  640  pixels per line (multiple of BLOCKSIZE)
// WPI        40   slice_mem FIFO depth; clear phase length in cycles
// RES_LAT    3    cycles from last window pixel (dvi out) to valid slice_mem output
// PORTS
// clk         in   1   clock
// reset       in   1   synchronous, active-high reset
// start       in   1   pulse: leave IDLE, begin clear+run loop
// abort       in   1   pulse: return to IDLE from any state
// fv_i        in   1   frame valid
// dv_i        in   1   pixel valid (qualified by fv_i)
// download    out  1   clear strobe to slice_mem
// dvi         out  1   pixel valid to slice_mem, 1 cycle after dv_i
// newblock    out  1   last pixel of block on current line, aligned with dvi
// coeff_addr  out  $clog2(WINCOLS*WINROWS)  coefficient index, aligned with dvi
// win_valid   out  1   1-cycle pulse: window result valid at slice_mem regout/msb
// frame_done  out  1   1-cycle pulse at end of frame
// busy        out  1   high in every state except IDLE
// err         out  1   sticky: frame ended mid-line/mid-block; cleared by start
// BEHAVIOUR
// - Reset: state IDLE, all counters 0, every output 0.
// - FSM: IDLE -start-> CLEAR -(WPI cycles)-> WAIT_SOF -fv_i rise-> RUN -fv_i fall-> DONE -> CLEAR.
// - abort: -> IDLE next cycle from any state; priority over all events except reset.
// - start outside IDLE: ignored.
// - CLEAR: download=1 for exactly WPI consecutive cycles. dvi=0.
// - WAIT_SOF: dv_i ignored. fv_i already high on entry is not a rising edge.
// - RUN: each dv_i&fv_i advances px_cnt (0..BLOCKSIZE-1).
//   - At wrap, blk_col advances (0..IMG_WIDTH/BLOCKSIZE-1).
//   - At blk_col wrap, line_cnt advances (0..BLOCKSIZE-1).
//   - At line_cnt wrap, blk_row advances (no wrap within frame).
// - dvi, newblock, coeff_addr: registered, latency 1 from dv_i.
//   - The integrator delays pixel data by 1 cycle to match.
//   - newblock=1 iff px_cnt==BLOCKSIZE-1.
//   - coeff_addr = (blk_row % WINROWS)*WINCOLS + (blk_col % WINCOLS).
// - win_valid: pulses RES_LAT cycles after a dvi whose pixel satisfies all of:
//   px_cnt==BLOCKSIZE-1, blk_col%WINCOLS==WINCOLS-1, line_cnt==BLOCKSIZE-1,
//   blk_row%WINROWS==WINROWS-1, blk_row>=WINROWS-1.
//   Delay line flushed by abort/reset.
// - DONE: one cycle. frame_done=1. err set if px_cnt!=0, blk_col!=0, or line_cnt!=0.
//   All counters then cleared.
// - fv_i fall and dv_i in the same cycle: the pixel is counted, then DONE.
// - dv_i while fv_i=0: ignored in every state.
// CONFIGURATION
// - SLICE_CTRL_STATS_EN defined:
//   - Adds output win_count[15:0], the number of win_valid pulses in the last completed frame.
//   - Updated when frame_done is set; saturates at 16'hFFFF; reset to 0.
// - Undefined: port absent, no counter logic.
// STRUCTURE
// - Package slicevm_pkg:
//   - state enum {IDLE,CLEAR,WAIT_SOF,RUN,DONE}
//   - width constants PX_W, BCOL_W, LINE_W, CADDR_W derived via $clog2.
// - Sub-module slice_ctrl_cnt:
//   - Enabled wrap counter with terminal-count flag and sync clear.
//   - Used for px_cnt, blk_col, line_cnt.
// TESTING (BLOCKSIZE=4, WINCOLS=2, WINROWS=2, IMG_WIDTH=16, WPI=8, RES_LAT=3)
// 1. start pulse -> download high cycles 1..8, then WAIT_SOF; busy=1; dvi stays 0.
// 2. Frame 16x8, dv_i every cycle:
//    - newblock on dvi #4,8,12,16 of each line.
//    - coeff_addr 0,0,0,0,1,1,1,1,0,... on line 0.
//    - coeff_addr = 2 or 3 on lines 4..7.
// 3. Same frame -> win_valid 3 cycles after dvi #(7*16+8) and #(7*16+16); exactly 2 pulses.
// 4. fv_i falls after 10 pixels of line 2 -> frame_done=1, err=1.
//    - CLEAR follows; err holds until start.
// 5. abort mid-RUN with dv_i active:
//    - IDLE next cycle; dvi/newblock/win_valid 0; no pending win_valid emitted.
// 6. reset asserted during CLEAR -> download=0 next cycle, all outputs 0.
//    - With SLICE_CTRL_STATS_EN, win_count=0; after scenario-3 frame, win_count=2.

Source files
------------

// File: rtl/slicevm_pkg.sv
// Shared types and width helpers for the slicevm sequencer (slice_ctrl and its counters).
// Width constants below describe the default 32-pixel / 8x16-block / 640-pixel-line configuration.
package slicevm_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLEAR    = 3'd1,
    WAIT_SOF = 3'd2,
    RUN      = 3'd3,
    DONE     = 3'd4
  } state_t;

  // Counter width that never collapses to zero bits for a range of one value.
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int BLOCKSIZE_D = 32;
  localparam int WINCOLS_D   = 8;
  localparam int WINROWS_D   = 16;
  localparam int IMG_WIDTH_D = 640;

  localparam int PX_W    = $clog2(BLOCKSIZE_D);
  localparam int BCOL_W  = $clog2(IMG_WIDTH_D / BLOCKSIZE_D);
  localparam int LINE_W  = $clog2(BLOCKSIZE_D);
  localparam int CADDR_W = $clog2(WINCOLS_D * WINROWS_D);

endpackage

// File: rtl/slice_ctrl_cnt.sv
// Enabled wrap counter 0..MAX with terminal-count flag; synchronous clear wins over enable.
module slice_ctrl_cnt #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tc ? '0 : r_cnt + W'(1);
    end
  end

  assign o_tc  = (r_cnt == W'(MAX));
  assign o_cnt = r_cnt;

endmodule

// File: rtl/slice_ctrl.sv
// Sequencer for the slice_mem accumulator chain: clear phase, per-frame position tracking, window flags.
// Optional SLICE_CTRL_STATS_EN adds win_count (window results in the last completed frame).
module slice_ctrl
  import slicevm_pkg::*;
#(
  parameter int BLOCKSIZE = 32,
  parameter int WINCOLS   = 8,
  parameter int WINROWS   = 16,
  parameter int IMG_WIDTH = 640,
  parameter int WPI       = 40,
  parameter int RES_LAT   = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            abort,
  input  logic                            fv_i,
  input  logic                            dv_i,
  output logic                            download,
  output logic                            dvi,
  output logic                            newblock,
  output logic [cw(WINCOLS*WINROWS)-1:0]  coeff_addr,
  output logic                            win_valid,
  output logic                            frame_done,
`ifdef SLICE_CTRL_STATS_EN
  output logic [15:0]                     win_count,
`endif
  output logic                            busy,
  output logic                            err,
  output state_t                          dbg_state
);

  localparam int PXW = cw(BLOCKSIZE);
  localparam int BCW = cw(IMG_WIDTH / BLOCKSIZE);
  localparam int LNW = cw(BLOCKSIZE);
  localparam int RWW = cw(WINROWS);
  localparam int CLW = cw(WPI);
  localparam int CAW = cw(WINCOLS * WINROWS);

  state_t           r_state, w_next;
  logic             r_fv_d;
  logic [CLW-1:0]   r_clr_cnt;
  logic             w_clr_tc;
  logic             w_pix, w_cnt_clr, w_frame_end, w_win_hit;
  logic [PXW-1:0]   w_px;
  logic [BCW-1:0]   w_col;
  logic [LNW-1:0]   w_line;
  logic [RWW-1:0]   w_row;
  logic             w_px_tc, w_col_tc, w_line_tc, w_row_tc;
  int               w_col_mod;
  logic [CAW-1:0]   w_caddr;
  logic             r_dvi, r_newblock, r_err;
  logic [CAW-1:0]   r_caddr;
  logic [RES_LAT:0] r_win_sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_fv_d  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_fv_d  <= fv_i;
    end
  end

  // abort overrides every transition; WAIT_SOF needs a genuine low-to-high fv_i edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (start) w_next = CLEAR;
      CLEAR:    if (w_clr_tc) w_next = WAIT_SOF;
      WAIT_SOF: if (fv_i && !r_fv_d) w_next = RUN;
      RUN:      if (!fv_i) w_next = DONE;
      DONE:     w_next = CLEAR;
      default:  w_next = IDLE;
    endcase
    if (abort) w_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset || r_state != CLEAR) begin
      r_clr_cnt <= '0;
    end else begin
      r_clr_cnt <= r_clr_cnt + CLW'(1);
    end
  end
  assign w_clr_tc = (r_clr_cnt == CLW'(WPI - 1));

  assign w_pix       = (r_state == RUN) && fv_i && dv_i && !abort;
  assign w_cnt_clr   = (r_state != RUN) || abort;
  assign w_frame_end = (r_state == RUN) && !fv_i && !abort;

  slice_ctrl_cnt #(.W(PXW), .MAX(BLOCKSIZE - 1)) u_px_cnt (
    .i_clk(clk), .i_rst(reset), .i_clr(w_cnt_clr), .i_en(w_pix),
    .o_cnt(w_px), .o_tc(w_px_tc)
  );

  slice_ctrl_cnt #(.W(BCW), .MAX(IMG_WIDTH / BLOCKSIZE - 1)) u_col_cnt (
    .i_clk(clk), .i_rst(reset), .i_clr(w_cnt_clr), .i_en(w_pix && w_px_tc),
    .o_cnt(w_col), .o_tc(w_col_tc)
  );

  slice_ctrl_cnt #(.W(LNW), .MAX(BLOCKSIZE - 1)) u_line_cnt (
    .i_clk(clk), .i_rst(reset), .i_clr(w_cnt_clr), .i_en(w_pix && w_px_tc && w_col_tc),
    .o_cnt(w_line), .o_tc(w_line_tc)
  );

  // Block row is only ever needed modulo WINROWS; a row index that is WINROWS-1 modulo
  // WINROWS is necessarily >= WINROWS-1, so no full-range row count is kept.
  slice_ctrl_cnt #(.W(RWW), .MAX(WINROWS - 1)) u_row_cnt (
    .i_clk(clk), .i_rst(reset), .i_clr(w_cnt_clr),
    .i_en(w_pix && w_px_tc && w_col_tc && w_line_tc),
    .o_cnt(w_row), .o_tc(w_row_tc)
  );

  always_comb begin
    w_col_mod = int'(w_col) % WINCOLS;
    w_caddr   = CAW'(int'(w_row) * WINCOLS + w_col_mod);
  end

  assign w_win_hit = w_pix && w_px_tc && (w_col_mod == WINCOLS - 1) && w_line_tc && w_row_tc;

  // dvi qualifies newblock/coeff_addr in the same cycle; the stream has no backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dvi      <= 1'b0;
      r_newblock <= 1'b0;
      r_caddr    <= '0;
      r_win_sr   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_dvi      <= w_pix;
      r_newblock <= w_pix && w_px_tc;
      r_caddr    <= w_pix ? w_caddr : '0;
      r_win_sr   <= abort ? '0 : {r_win_sr[RES_LAT-1:0], w_win_hit};
      if (r_state == IDLE && start && !abort) begin
        r_err <= 1'b0;
      end else if (w_frame_end && (w_px != '0 || w_col != '0 || w_line != '0)) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef SLICE_CTRL_STATS_EN
  logic [15:0] r_win_acc, r_win_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_win_acc   <= '0;
      r_win_count <= '0;
    end else begin
      if (r_state != RUN) begin
        r_win_acc <= '0;
      end else if (w_win_hit && r_win_acc != 16'hFFFF) begin
        r_win_acc <= r_win_acc + 16'd1;
      end
      if (w_frame_end) r_win_count <= r_win_acc;
    end
  end

  assign win_count = r_win_count;
`endif

  assign download   = (r_state == CLEAR);
  assign frame_done = (r_state == DONE);
  assign busy       = (r_state != IDLE);
  assign dvi        = r_dvi;
  assign newblock   = r_newblock;
  assign coeff_addr = r_caddr;
  assign win_valid  = r_win_sr[RES_LAT];
  assign err        = r_err;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_slice_ctrl.sv
// Directed bench for slice_ctrl with a pixel-index reference model and per-cycle output compare.
module tb_slice_ctrl;
  import slicevm_pkg::*;

  localparam int BS  = 4;
  localparam int WC  = 2;
  localparam int WR  = 2;
  localparam int IW  = 16;
  localparam int WPI = 8;
  localparam int RL  = 3;
  localparam int CAW = $clog2(WC * WR);

  localparam int M_IDLE  = 0;
  localparam int M_CLEAR = 1;
  localparam int M_WAIT  = 2;
  localparam int M_RUN   = 3;
  localparam int M_DONE  = 4;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset, start, abort, fv_i, dv_i;
  logic download, dvi, newblock, win_valid, frame_done, busy, err;
  logic [CAW-1:0] coeff_addr;
  state_t dbg_state;
`ifdef SLICE_CTRL_STATS_EN
  logic [15:0] win_count;
`endif

  always #5 clk = ~clk;

  slice_ctrl #(
    .BLOCKSIZE(BS), .WINCOLS(WC), .WINROWS(WR), .IMG_WIDTH(IW), .WPI(WPI), .RES_LAT(RL)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .fv_i(fv_i), .dv_i(dv_i),
    .download(download), .dvi(dvi), .newblock(newblock), .coeff_addr(coeff_addr),
    .win_valid(win_valid), .frame_done(frame_done),
`ifdef SLICE_CTRL_STATS_EN
    .win_count(win_count),
`endif
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- model state ----------------
  int n_vec = 0;
  int n_miss = 0;
  int m_mode = M_IDLE;
  int m_clr_left = 0;
  int m_n = 0;
  int m_wins = 0;
  int m_wc = 0;
  int m_cyc = 0;
  bit m_fv_prev = 1'b0;
  bit m_err = 1'b0;
  logic [31:0] exp_q[$];
  bit e_dl, e_busy, e_fd, e_err, e_dvi, e_nb, e_win;
  int e_ca;
  bit chk_en = 1'b0;

  // observations for the literal checks
  int obs_dl, obs_win, obs_nb, obs_dvi, obs_fd;
  bit fd_err;
  int obs_ca[16];
  int win_cyc[$];
  int dvi_cyc[$];
  int ca_line0[16] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, m_cyc, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit rst, input bit st, input bit ab, input bit fv, input bit dv);
    bit pix;
    int x, y;
    reset = rst; start = st; abort = ab; fv_i = fv; dv_i = dv;
    @(posedge clk);
    m_cyc++;
    pix   = !rst && (m_mode == M_RUN) && fv && dv && !ab;
    e_dvi = pix;
    e_nb  = 1'b0;
    e_ca  = 0;
    if (pix) begin
      x = m_n % IW;
      y = m_n / IW;
      e_nb = ((x % BS) == BS - 1);
      e_ca = ((y / BS) % WR) * WC + (x / BS) % WC;
      if ((x % BS) == BS - 1 && ((x / BS) % WC) == WC - 1 &&
          (y % BS) == BS - 1 && ((y / BS) % WR) == WR - 1) begin
        exp_q.push_back(32'(m_cyc + RL));
        m_wins++;
      end
      m_n++;
    end
    if (rst) begin
      m_mode = M_IDLE; m_err = 1'b0; m_wc = 0; exp_q.delete(); m_n = 0; m_wins = 0;
    end else if (ab) begin
      m_mode = M_IDLE; exp_q.delete(); m_n = 0;
    end else begin
      case (m_mode)
        M_IDLE:  if (st) begin m_mode = M_CLEAR; m_clr_left = WPI; m_err = 1'b0; end
        M_CLEAR: begin m_clr_left--; if (m_clr_left == 0) m_mode = M_WAIT; end
        M_WAIT:  if (fv && !m_fv_prev) begin m_mode = M_RUN; m_n = 0; m_wins = 0; end
        M_RUN:   if (!fv) begin
                   m_mode = M_DONE;
                   if ((m_n % IW) != 0 || ((m_n / IW) % BS) != 0) m_err = 1'b1;
                   m_wc = (m_wins > 65535) ? 65535 : m_wins;
                 end
        default: begin m_mode = M_CLEAR; m_clr_left = WPI; end
      endcase
    end
    m_fv_prev = rst ? 1'b0 : fv;
    e_win = (exp_q.size() > 0 && exp_q[0] == 32'(m_cyc));
    if (e_win) void'(exp_q.pop_front());
    e_dl   = (m_mode == M_CLEAR);
    e_busy = (m_mode != M_IDLE);
    e_fd   = (m_mode == M_DONE);
    e_err  = m_err;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame(input int npix, input bit gaps);
    int k;
    k = 0;
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    while (k < npix) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end else begin
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        k++;
      end
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_obs();
    obs_dl = 0; obs_win = 0; obs_nb = 0; obs_dvi = 0; obs_fd = 0; fd_err = 1'b0;
    win_cyc.delete(); dvi_cyc.delete();
    for (int i = 0; i < 16; i++) obs_ca[i] = -1;
  endtask

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("download", download, e_dl);
      chk("busy", busy, e_busy);
      chk("frame_done", frame_done, e_fd);
      chk("err", err, e_err);
      chk("dvi", dvi, e_dvi);
      chk("win_valid", win_valid, e_win);
      if (e_dvi) begin
        chk("newblock", newblock, e_nb);
        chk("coeff_addr", coeff_addr, e_ca);
      end
`ifdef SLICE_CTRL_STATS_EN
      chk("win_count", win_count, m_wc);
`endif
      if (download) obs_dl++;
      if (newblock) obs_nb++;
      if (frame_done) begin obs_fd++; fd_err = err; end
      if (win_valid) begin obs_win++; win_cyc.push_back(m_cyc); end
      if (dvi) begin
        obs_dvi++;
        if (obs_dvi <= 16) obs_ca[obs_dvi-1] = int'(coeff_addr);
        if (obs_dvi == 120 || obs_dvi == 128) dvi_cyc.push_back(m_cyc);
      end
    end
  end

  // ---------------- directed scenarios ----------------
  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; fv_i = 1'b0; dv_i = 1'b0;
    clear_obs();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_state", dbg_state, IDLE);
    idle(2);

    // start -> eight clear cycles -> waiting for start of frame
    clear_obs();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(WPI + 3);
    chk("clear_len", obs_dl, 8);
    chk("state_wait", dbg_state, WAIT_SOF);

    // full 16x8 frame, pixel every cycle
    clear_obs();
    frame(128, 1'b0);
    idle(6);
    chk("win_pulses", obs_win, 2);
    chk("newblock_n", obs_nb, 32);
    chk("frame_done_n", obs_fd, 1);
    chk("frame_err", fd_err, 0);
    for (int i = 0; i < 16; i++) chk("ca_line0", obs_ca[i], ca_line0[i]);
    chk("win_cyc_n", win_cyc.size(), 2);
    chk("dvi_cyc_n", dvi_cyc.size(), 2);
    if (win_cyc.size() == 2 && dvi_cyc.size() == 2) begin
      chk("win_lat0", win_cyc[0] - dvi_cyc[0], 3);
      chk("win_lat1", win_cyc[1] - dvi_cyc[1], 3);
    end
`ifdef SLICE_CTRL_STATS_EN
    chk("win_count_frame", win_count, 2);
`endif

    // same frame with random pixel gaps
    idle(WPI + 4);
    clear_obs();
    frame(128, 1'b1);
    idle(6);
    chk("gap_win_pulses", obs_win, 2);
    chk("gap_newblock_n", obs_nb, 32);

    // frame ends 10 pixels into line 2
    idle(WPI + 4);
    clear_obs();
    frame(42, 1'b0);
    idle(2);
    chk("short_done_n", obs_fd, 1);
    chk("short_err", fd_err, 1);
    idle(12);
    chk("err_sticky", err, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("err_cleared", err, 0);
    idle(WPI + 2);

    // abort right after the window's last pixel, with pixels still arriving
    clear_obs();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 120; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    obs_win = 0;
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("abort_idle", dbg_state, IDLE);
    chk("abort_dvi", dvi, 0);
    idle(6);
    chk("abort_no_win", obs_win, 0);

    // reset in the middle of the clear phase
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_clear_dl", download, 0);
    chk("rst_clear_busy", busy, 0);
`ifdef SLICE_CTRL_STATS_EN
    chk("rst_win_count", win_count, 0);
`endif
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
